// File: rtl/fp_result_packer.sv
//------------------------------------------------------------------------------
// Module      : fp_result_packer
// Description : float32 multiplier output stage. Normalizes, rounds to nearest-even,
//               packs the result and raises exception flags in a 2-stage valid/ready pipeline.
//               Optional macro FP_STICKY_FLAGS_EN adds accumulated sticky flags.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_result_packer #(
  parameter int EXP_W = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_special,
  input  logic                    in_snan,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [47:0]             in_mant,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result,
  output logic [3:0]              out_flags
`ifdef FP_STICKY_FLAGS_EN
  ,
  input  logic                    flags_clr,
  output logic [3:0]              sticky_flags
`endif
);

  localparam int XW = EXP_W + 2;

  logic adv1, adv2;

  // Stage 1 state
  logic                  s1_valid_q;
  logic [22:0]           s1_frac_q, s1_frac_d;
  logic                  s1_guard_q, s1_guard_d;
  logic                  s1_sticky_q, s1_sticky_d;
  logic signed [EXP_W:0] s1_exp_q, s1_exp_d;
  logic [3:0]            s1_special_q;
  logic                  s1_snan_q;
  logic                  s1_sign_q;

  // Stage 2 state
  logic                  s2_valid_q;
  logic [31:0]           result_q, result_d;
  logic [3:0]            flags_q, flags_d;

  logic                  round_up;
  logic [23:0]           frac_sum;
  logic signed [XW-1:0]  exp_rnd;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    s1_frac_d   = in_mant[45:23];
    s1_guard_d  = in_mant[22];
    s1_sticky_d = |in_mant[21:0];
    s1_exp_d    = {in_exp[EXP_W-1], in_exp};
    if (in_mant[47]) begin
      s1_frac_d   = in_mant[46:24];
      s1_guard_d  = in_mant[23];
      s1_sticky_d = |in_mant[22:0];
      s1_exp_d    = {in_exp[EXP_W-1], in_exp} + (EXP_W+1)'(1);
    end
  end

  always_comb begin
    round_up = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
    frac_sum = {1'b0, s1_frac_q} + {23'b0, round_up};
    // A carry out of the fraction leaves frac_sum[22:0] at zero and bumps the exponent.
    exp_rnd  = {s1_exp_q[EXP_W], s1_exp_q} + XW'(frac_sum[23]);
    result_d = {s1_sign_q, exp_rnd[7:0], frac_sum[22:0]};
    flags_d  = {3'b000, s1_guard_q | s1_sticky_q};
    if (exp_rnd >= $signed(XW'(255))) begin
      result_d = {s1_sign_q, 8'hFF, 23'b0};
      flags_d  = 4'b0101;
    end else if (exp_rnd <= $signed(XW'(0))) begin
      result_d = {s1_sign_q, 31'b0};
      flags_d  = 4'b0011;
    end
    if (s1_special_q[3]) begin
      result_d = 32'h7FC00000;
      flags_d  = {s1_snan_q, 3'b000};
    end else if (s1_special_q[2]) begin
      result_d = 32'h7FC00000;
      flags_d  = 4'b1000;
    end else if (s1_special_q[1]) begin
      result_d = {s1_sign_q, 31'b0};
      flags_d  = 4'b0000;
    end else if (s1_special_q[0]) begin
      result_d = {s1_sign_q, 8'hFF, 23'b0};
      flags_d  = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_frac_q    <= '0;
      s1_guard_q   <= 1'b0;
      s1_sticky_q  <= 1'b0;
      s1_exp_q     <= '0;
      s1_special_q <= '0;
      s1_snan_q    <= 1'b0;
      s1_sign_q    <= 1'b0;
    end else if (adv1) begin
      s1_valid_q   <= in_valid;
      s1_frac_q    <= s1_frac_d;
      s1_guard_q   <= s1_guard_d;
      s1_sticky_q  <= s1_sticky_d;
      s1_exp_q     <= s1_exp_d;
      s1_special_q <= in_special;
      s1_snan_q    <= in_snan;
      s1_sign_q    <= in_sign;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;

`ifdef FP_STICKY_FLAGS_EN
  logic [3:0] sticky_q;
  logic       xfer;

  assign xfer = s2_valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (flags_clr) begin
      sticky_q <= xfer ? flags_q : 4'b0000;
    end else if (xfer) begin
      sticky_q <= sticky_q | flags_q;
    end
  end

  assign sticky_flags = sticky_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_result_packer.sv
//------------------------------------------------------------------------------
// Module      : tb_fp_result_packer
// Description : Directed self-checking bench for fp_result_packer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_result_packer;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_special;
  logic              in_snan;
  logic              in_sign;
  logic signed [9:0] in_exp;
  logic [47:0]       in_mant;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [3:0]        out_flags;
`ifdef FP_STICKY_FLAGS_EN
  logic              flags_clr = 1'b0;
  logic [3:0]        sticky_flags;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_result_packer #(.EXP_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_special (in_special),
    .in_snan    (in_snan),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
`ifdef FP_STICKY_FLAGS_EN
    ,
    .flags_clr    (flags_clr),
    .sticky_flags (sticky_flags)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [3:0] sp, input logic sn, input logic sg,
                       input logic signed [9:0] ex, input logic [47:0] mt);
    in_special = sp;
    in_snan    = sn;
    in_sign    = sg;
    in_exp     = ex;
    in_mant    = mt;
  endtask

  // Called just after a falling edge with an empty pipeline and out_ready=1.
  task automatic run1(input string tag, input logic [3:0] sp, input logic sn, input logic sg,
                      input logic signed [9:0] ex, input logic [47:0] mt,
                      input logic [31:0] eres, input logic [3:0] eflg);
    drive(sp, sn, sg, ex, mt);
    in_valid = 1'b1;
    chk({tag, "_rdy"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_res"}, out_result, eres);
    chk({tag, "_flg"}, {28'b0, out_flags}, {28'b0, eflg});
  endtask

  initial begin
    int acc;
    int idx;
    logic [31:0] bp_exp [4];
    bp_exp[0] = 32'h40000000;
    bp_exp[1] = 32'h40800000;
    bp_exp[2] = 32'h41000000;
    bp_exp[3] = 32'h41800000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(4'b0000, 1'b0, 1'b0, 10'sd0, 48'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_flags", {28'b0, out_flags}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    run1("m1p5x2",   4'b0000, 1'b0, 1'b0, 10'sd128, 48'h600000000000, 32'h40400000, 4'b0000);
    run1("m1p5x1p5", 4'b0000, 1'b0, 1'b0, 10'sd127, 48'h900000000000, 32'h40100000, 4'b0000);
    run1("tie_even", 4'b0000, 1'b0, 1'b0, 10'sd127, 48'h400000400000, 32'h3F800000, 4'b0001);
    run1("tie_odd",  4'b0000, 1'b0, 1'b0, 10'sd127, 48'h400000C00000, 32'h3F800002, 4'b0001);
    run1("zxinf",    4'b0100, 1'b0, 1'b0, 10'sd0,   48'h0,            32'h7FC00000, 4'b1000);
    run1("infneg",   4'b0001, 1'b0, 1'b1, 10'sd0,   48'h0,            32'hFF800000, 4'b0000);
    run1("qnan",     4'b1000, 1'b0, 1'b0, 10'sd0,   48'h0,            32'h7FC00000, 4'b0000);
    run1("multi",    4'b1111, 1'b1, 1'b1, 10'sd127, 48'h400000000000, 32'h7FC00000, 4'b1000);
    run1("zeroneg",  4'b0010, 1'b0, 1'b1, 10'sd127, 48'h400000000000, 32'h80000000, 4'b0000);
    run1("ovf",      4'b0000, 1'b0, 1'b0, 10'sd254, 48'h900000000000, 32'h7F800000, 4'b0101);
    run1("rnd_ovf",  4'b0000, 1'b0, 1'b0, 10'sd254, 48'h7FFFFFC00000, 32'h7F800000, 4'b0101);
    run1("unf",      4'b0000, 1'b0, 1'b0, 10'sd0,   48'h400000000000, 32'h00000000, 4'b0011);
    run1("unf_neg",  4'b0000, 1'b0, 1'b1, -10'sd3,  48'h400000000000, 32'h80000000, 4'b0011);

    // Backpressure: four offers against a stalled consumer
    @(negedge clk);
    out_ready = 1'b0;
    acc = 0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(4'b0000, 1'b0, 1'b0, 10'(128 + idx), 48'h400000000000);
      in_valid = 1'b1;
      if (in_ready) begin
        acc++;
        idx++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_hold_res", out_result, bp_exp[0]);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_order1_vld", {31'b0, out_valid}, 32'd1);
    chk("bp_order1_res", out_result, bp_exp[1]);
    @(posedge clk);
    @(negedge clk);
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Stream two more beats, then reset with one in each stage
    drive(4'b0000, 1'b0, 1'b0, 10'sd130, 48'h400000000000);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(4'b0000, 1'b0, 1'b0, 10'sd131, 48'h400000000000);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("str_res", out_result, bp_exp[2]);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mid_res", out_result, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_rel_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_no_ghost", {31'b0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_result_packer.md
Name: fp_result_packer

Overview:
- Output stage of the float32 multiplier. Takes the raw 48-bit significand product, the signed biased exponent sum, the result sign and the 4-bit special-case code produced by the operation analyzer.
- Normalizes, rounds to nearest-even and packs the IEEE-754 single-precision result with exception flags.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 10: width of the signed biased exponent input. Must be >= 10.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  packer can accept a beat
- in_special  in  4  [3] NaN, [2] 0*inf, [1] 0*num, [0] inf*num; 0000 = regular product
- in_snan  in  1  at least one operand is a signaling NaN
- in_sign  in  1  result sign (sign_a ^ sign_b)
- in_exp  in  EXP_W  signed biased exponent, exp_a + exp_b - 127
- in_mant  in  48  1.23 x 1.23 product, binary point between bits 46 and 45
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  32  packed float32
- out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset, asynchronous, active-high: both stage valid bits = 0, out_valid = 0, out_result = 0, out_flags = 0, in_ready = 1 after reset releases.
- Handshake:
  - A beat transfers when valid && ready on the same edge.
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational, no dependence on in_valid).
  - out_result and out_flags stay stable while out_valid && !out_ready.
- Latency: 2 cycles from an accepted input to out_valid when not stalled. Throughput: 1 beat per cycle. Order is preserved; no beat is dropped or duplicated.
- Stage 1 (normalize), registered when adv1:
  - If in_mant[47]=1: frac = mant[46:24], guard = mant[23], sticky = |mant[22:0], exp = in_exp + 1.
  - Otherwise: frac = mant[45:23], guard = mant[22], sticky = |mant[21:0], exp = in_exp.
  - in_special, in_snan and in_sign are carried forward.
- Stage 2 (round/pack), registered when adv2:
  - Round up when guard && (sticky || frac[0]).
  - Rounding carry out of frac: frac = 0, exp + 1.
  - inexact = guard | sticky.
  - exp >= 255: result = {sign, 8'hFF, 0}, overflow = 1, inexact = 1.
  - exp <= 0: flush to signed zero {sign, 31'b0}, underflow = 1, inexact = 1 (no denormal outputs; matches the analyzer treating denormals as zero).
  - Otherwise: result = {sign, exp[7:0], frac}.
- Special-case priority, evaluated before rounding and overriding it:
  - [3] NaN: 32'h7FC00000, invalid = in_snan.
  - [2] 0*inf: 32'h7FC00000, invalid = 1.
  - [1] zero: {sign, 31'b0}.
  - [0] inf: {sign, 8'hFF, 23'b0}.
  - No overflow, underflow or inexact flags for special cases.
- Simultaneous events: the upstream analyzer guarantees one-hot in_special. If multiple bits are set anyway, the highest bit wins.
- Reset mid-operation: in-flight beats are discarded; no partial result is ever presented.

Optional Feature:
- Macro: FP_STICKY_FLAGS_EN.
- Defined: adds ports flags_clr (in, 1) and sticky_flags (out, 4).
  - sticky_flags ORs in out_flags on every out_valid && out_ready transfer.
  - flags_clr synchronously zeroes sticky_flags. If flags_clr coincides with a transfer, that transfer's flags are retained.
  - sticky_flags resets to 0.
- Undefined: neither port nor the register exists; all other behaviour is unchanged.

Test Plan:
- 1.5*2.0: in_mant = 48'h600000000000, in_exp = 128, in_special = 0 -> out_result = 32'h40400000, flags 0, two cycles after acceptance.
- 1.5*1.5: in_mant = 48'h900000000000, in_exp = 127 -> 32'h40100000 (normalization shift).
- Rounding ties: in_mant = 48'h400000400000, in_exp = 127 (guard = 1, sticky = 0, lsb = 0) -> 32'h3F800000, inexact = 1. Setting bit 23 as well (lsb = 1) -> 32'h3F800002.
- Special cases:
  - in_special = 0100 -> 32'h7FC00000, invalid = 1.
  - in_special = 0001, sign = 1 -> 32'hFF800000.
  - in_special = 1000, in_snan = 0 -> 32'h7FC00000, flags 0.
- Overflow/underflow:
  - in_exp = 254, in_mant = 48'h900000000000 -> 32'h7F800000, flags 0101.
  - in_exp = 0, in_mant = 48'h400000000000 -> 32'h00000000, flags 0011.
- Backpressure: hold out_ready = 0, offer 4 beats back-to-back -> exactly 2 accepted, in_ready = 0. Release out_ready -> results in order, 1 per cycle. Assert rst mid-stream -> out_valid = 0 immediately, in_ready = 1 after release.
